// File: rtl/mult_prec_pkg.sv
// Shared definitions for the precision-configurable multiplier: mode encodings
// and lane-count helpers.
package mult_prec_pkg;

   typedef enum logic [1:0] {
      PREC_4B     = 2'b00,
      PREC_8B     = 2'b01,
      PREC_FULL   = 2'b10,
      PREC_FULL_X = 2'b11
   } prec_e;

   function automatic int lanes4(input int w);
      return w / 4;
   endfunction

   function automatic int lanes8(input int w);
      return w / 8;
   endfunction

endpackage

// File: rtl/mult_lane_pp.sv
// Radix-4 Booth partial-product rows for one W x W operand pair, with rows
// confined to their lane (operand sign-extended, result field masked) in SIMD modes.
module mult_lane_pp
   import mult_prec_pkg::*;
#(
   parameter int W = 12
) (
   input  logic [W-1:0]             a_i,
   input  logic [W-1:0]             b_i,
   input  prec_e                    mode_i,
   output logic [W/2-1:0][2*W-1:0]  pp_o
);

   localparam int PW = 2 * W;
   localparam int NR = W / 2;
   localparam int N8 = lanes8(W);

   logic [W:0] bx;
   assign bx = {b_i, 1'b0};

   // Booth digit from {b[2r+1], b[2r], b[2r-1]} applied to a sign-extended multiplicand
   function automatic logic [PW-1:0] booth_row(input logic [2:0] sel, input logic [PW-1:0] a);
      logic [PW-1:0] mag;
      unique case (sel)
         3'b001, 3'b010, 3'b101, 3'b110: mag = a;
         3'b011, 3'b100:                 mag = a << 1;
         default:                        mag = '0;
      endcase
      return sel[2] ? -mag : mag;
   endfunction

   for (genvar r = 0; r < NR; r++) begin : g_row
      localparam int L4 = r / 2;
      localparam int S4 = 2 * r - 4 * L4;
      localparam int L8 = r / 4;
      localparam int S8 = 2 * r - 8 * L8;

      logic [2:0]    sel_full, sel4, sel8;
      logic [PW-1:0] row_full, row4, row8;

      // The digit's low bit is forced to 0 at a lane boundary so lanes stay independent
      assign sel_full = bx[2*r+2 -: 3];
      assign sel4     = {bx[2*r+2 -: 2], (S4 == 0) ? 1'b0 : bx[2*r]};
      assign sel8     = {bx[2*r+2 -: 2], (S8 == 0) ? 1'b0 : bx[2*r]};

      assign row_full = booth_row(sel_full, {{W{a_i[W-1]}}, a_i}) << (2 * r);

      assign row4 = ((booth_row(sel4, {{(PW-4){a_i[4*L4+3]}}, a_i[4*L4 +: 4]}) << S4)
                     & {{(PW-8){1'b0}}, 8'hFF}) << (8 * L4);

      if (L8 < N8) begin : g_l8
         assign row8 = ((booth_row(sel8, {{(PW-8){a_i[8*L8+7]}}, a_i[8*L8 +: 8]}) << S8)
                        & {{(PW-16){1'b0}}, 16'hFFFF}) << (16 * L8);
      end else begin : g_z8
         assign row8 = '0;
      end

      assign pp_o[r] = (mode_i == PREC_4B) ? row4 :
                       (mode_i == PREC_8B) ? row8 : row_full;
   end

endmodule

// File: rtl/mult_prec_pipe.sv
// Two-stage pipelined signed multiplier with 4/8-bit SIMD lanes, valid/ready
// handshake with full backpressure and a sideband tag.
module mult_prec_pipe
   import mult_prec_pkg::*;
#(
   parameter int W     = 12,
   parameter int TAG_W = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [1:0]         i_Numerical_Precision,
   input  logic [TAG_W-1:0]   i_tag,
   input  logic [W-1:0]       A_NUM,
   input  logic [W-1:0]       B_NUM,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [2*W-1:0]     C_NUM,
   output logic [TAG_W-1:0]   o_tag
);

   localparam int PW  = 2 * W;
   localparam int NR  = W / 2;
   localparam int NCH = PW / 8;

   prec_e                   mode_in;
   logic [NR-1:0][PW-1:0]   pp_in;

   logic                    vld_p1_q, vld_p1_d;
   logic [NR-1:0][PW-1:0]   pp_p1_q;
   prec_e                   mode_p1_q;
   logic [TAG_W-1:0]        tag_p1_q;

   logic                    vld_p2_q, vld_p2_d;
   logic [PW-1:0]           c_p2_q, c_p2_d;
   logic [TAG_W-1:0]        tag_p2_q;

   logic                    adv, accept;

   assign mode_in = prec_e'(i_Numerical_Precision);

   mult_lane_pp #(.W(W)) u_pp (
      .a_i    (A_NUM),
      .b_i    (B_NUM),
      .mode_i (mode_in),
      .pp_o   (pp_in)
   );

   // Byte-chunked adder whose inter-chunk carries are cut at the active lane boundaries
   function automatic logic [PW-1:0] seg_add(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                             input prec_e m);
      logic [PW-1:0] s;
      logic          cy;
      logic [8:0]    t;
      s  = '0;
      cy = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (c != 0 && (m == PREC_4B || (m == PREC_8B && (c % 2) == 0))) cy = 1'b0;
         t  = {1'b0, a[8*c +: 8]} + {1'b0, b[8*c +: 8]} + {8'b0, cy};
         s[8*c +: 8] = t[7:0];
         cy = t[8];
      end
      return s;
   endfunction

   assign adv     = !vld_p2_q || i_ready;
   assign o_ready = !vld_p1_q || adv;
   assign accept  = i_valid && o_ready;

   always_comb begin
      vld_p1_d = vld_p1_q;
      if (accept)   vld_p1_d = 1'b1;
      else if (adv) vld_p1_d = 1'b0;
      vld_p2_d = adv ? vld_p1_q : vld_p2_q;
   end

   always_comb begin
      c_p2_d = '0;
      for (int r = 0; r < NR; r++) c_p2_d = seg_add(c_p2_d, pp_p1_q[r], mode_p1_q);
   end

   // s1: partial products, mode and tag
   always_ff @(posedge i_clk) begin
      if (accept) begin
         pp_p1_q   <= pp_in;
         mode_p1_q <= mode_in;
         tag_p1_q  <= i_tag;
      end
   end

   // s2: reduced, lane-formatted result
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         c_p2_q   <= '0;
         tag_p2_q <= '0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         if (adv && vld_p1_q) begin
            c_p2_q   <= c_p2_d;
            tag_p2_q <= tag_p1_q;
         end
      end
   end

   assign o_valid = vld_p2_q;
   assign C_NUM   = c_p2_q;
   assign o_tag   = tag_p2_q;

endmodule

// File: tb/tb_mult_prec_pipe.sv
// Directed bench for mult_prec_pipe (W=12, TAG_W=4) with a queue scoreboard.
module tb_mult_prec_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid, o_ready, o_valid, i_ready;
   logic [1:0]  prec;
   logic [3:0]  i_tag, o_tag;
   logic [11:0] a_num, b_num;
   logic [23:0] c_num;

   mult_prec_pipe #(.W(12), .TAG_W(4)) dut (
      .i_clk                 (clk),
      .i_rst_n               (rst_n),
      .i_valid               (i_valid),
      .o_ready               (o_ready),
      .i_Numerical_Precision (prec),
      .i_tag                 (i_tag),
      .A_NUM                 (a_num),
      .B_NUM                 (b_num),
      .o_valid               (o_valid),
      .i_ready               (i_ready),
      .C_NUM                 (c_num),
      .o_tag                 (o_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] c;
      logic [3:0]  tag;
      int          acc_edge;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0, n_pass = 0, edge_cnt = 0, stall_acc = 0;
   bit          lat_on = 1'b1, held_ok = 1'b0, last_acc;
   logic [23:0] held_c;
   logic [3:0]  held_tag;

   function automatic logic [23:0] model(input logic [1:0] m, input logic [11:0] a,
                                         input logic [11:0] b);
      logic [23:0]        r;
      logic signed [3:0]  x4, y4;
      logic signed [7:0]  x8, y8, p8;
      logic signed [15:0] x16, y16, p16;
      logic signed [23:0] x24, y24;
      r = '0;
      case (m)
         2'b00: for (int i = 0; i < 3; i++) begin
            x4 = a[4*i +: 4]; y4 = b[4*i +: 4];
            x8 = x4; y8 = y4; p8 = x8 * y8;
            r[8*i +: 8] = p8;
         end
         2'b01: begin
            x8 = a[7:0]; y8 = b[7:0];
            x16 = x8; y16 = y8; p16 = x16 * y16;
            r[15:0] = p16;
         end
         default: begin
            x24 = $signed(a); y24 = $signed(b);
            r = x24 * y24;
         end
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input bit v, input logic [1:0] m, input logic [11:0] a,
                        input logic [11:0] b, input logic [3:0] t);
      i_valid = v; prec = m; a_num = a; b_num = b; i_tag = t;
   endtask

   // Called just after a falling edge with inputs driven; ends at the next falling edge.
   task automatic tick();
      bit          acc, ret;
      logic [23:0] oc;
      logic [3:0]  ot;
      exp_t        e;
      #2;
      acc = i_valid && o_ready;
      ret = o_valid && i_ready;
      oc  = c_num;
      ot  = o_tag;
      if (!i_ready && o_valid) begin
         if (held_ok) begin
            chk("hold_c", 32'(oc), 32'(held_c));
            chk("hold_tag", 32'(ot), 32'(held_tag));
         end
         held_ok = 1'b1; held_c = oc; held_tag = ot;
      end else begin
         held_ok = 1'b0;
      end
      if (acc && !i_ready) stall_acc++;
      if (acc) sb.push_back('{model(prec, a_num, b_num), i_tag, edge_cnt + 1, lat_on});
      @(posedge clk);
      edge_cnt++;
      if (ret) begin
         chk("ret_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("c_num", 32'(oc), 32'(e.c));
            chk("o_tag", 32'(ot), 32'(e.tag));
            if (e.lat) chk("latency", 32'(edge_cnt - e.acc_edge), 32'd2);
         end
      end
      last_acc = acc;
      @(negedge clk);
   endtask

   initial begin
      int          sent;
      logic [11:0] ra, rb;
      rst_n = 1'b1; i_ready = 1'b1;
      drive(1'b0, 2'b00, 12'h000, 12'h000, 4'h0);
      #1 rst_n = 1'b0;
      #12;
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_c_num", 32'(c_num), 32'd0);
      chk("rst_o_tag", 32'(o_tag), 32'd0);
      chk("rst_o_ready", 32'(o_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // single transaction, latency and full-mode product
      drive(1'b1, 2'b10, 12'hFFF, 12'h7FF, 4'h5);
      tick();
      drive(1'b0, 2'b10, 12'h000, 12'h000, 4'h0);
      chk("lat_early_vld", 32'(o_valid), 32'd0);
      chk("full_model", 32'(model(2'b10, 12'hFFF, 12'h7FF)), 32'hFFF801);
      repeat (3) tick();

      // back-to-back SIMD and mode-11 vectors
      drive(1'b1, 2'b00, 12'h7F8, 12'h37F, 4'h1); tick();
      drive(1'b1, 2'b01, 12'hA80, 12'h5FF, 4'h2); tick();
      drive(1'b1, 2'b11, 12'h002, 12'hFFD, 4'h3); tick();
      drive(1'b1, 2'b00, 12'h888, 12'h888, 4'h4); tick();
      drive(1'b1, 2'b01, 12'hF80, 12'hF80, 4'h6); tick();
      drive(1'b0, 2'b00, 12'h000, 12'h000, 4'h0);
      repeat (3) tick();

      // stream of 8 tags with mixed modes, downstream stalled for cycles 3-7
      lat_on = 1'b0; stall_acc = 0; sent = 0;
      ra = 12'($urandom); rb = 12'($urandom);
      for (int cyc = 0; cyc < 60 && (sent < 8 || sb.size() > 0); cyc++) begin
         i_ready = !(cyc >= 3 && cyc <= 7);
         if (cyc >= 3 && sent < 8) drive(1'b1, 2'(sent), ra, rb, 4'(sent));
         else drive(1'b0, 2'b00, 12'h000, 12'h000, 4'h0);
         if (cyc == 6) begin
            #1 chk("full_o_ready", 32'(o_ready), 32'd0);
         end
         tick();
         if (last_acc) begin
            sent++;
            ra = 12'($urandom); rb = 12'($urandom);
         end
      end
      chk("stall_accepts", 32'(stall_acc), 32'd2);
      chk("stream_sent", 32'(sent), 32'd8);
      chk("stream_drained", 32'(sb.size()), 32'd0);

      // fill the pipeline, then reset asynchronously mid-cycle
      lat_on = 1'b1; i_ready = 1'b0;
      drive(1'b1, 2'b10, 12'h123, 12'h456, 4'hA); tick();
      drive(1'b1, 2'b00, 12'h777, 12'h999, 4'hB); tick();
      drive(1'b0, 2'b00, 12'h000, 12'h000, 4'h0);
      #1 chk("full_before_rst", 32'(o_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_o_valid", 32'(o_valid), 32'd0);
      chk("arst_c_num", 32'(c_num), 32'd0);
      chk("arst_o_tag", 32'(o_tag), 32'd0);
      chk("arst_o_ready", 32'(o_ready), 32'd1);
      sb.delete();
      held_ok = 1'b0;
      #10 rst_n = 1'b1;
      @(negedge clk);
      i_ready = 1'b1;
      drive(1'b1, 2'b10, 12'h800, 12'h800, 4'hC); tick();
      drive(1'b0, 2'b00, 12'h000, 12'h000, 4'h0);
      repeat (3) tick();

      for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
      chk("final_drain", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
